// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-slice pipeline register with valid, stall, flush and bubble ctrl zeroing
// Ports: clk/reset (sync, active-high); stall holds, flush bubbles all slices;
// valid_in/ctrl_in/data_in from upstream; valid_out/ctrl_out/data_out from last slice;
// occupancy = count of valid slices. Optional macro PIPE_STAGE_PERF_EN adds
// saturating stall_cycles and bubble_cycles counters.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int DEPTH = 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       bubble_cycles
`endif
);
  logic [DEPTH-1:0]  r_valid;
  logic [CTRL_W-1:0] r_ctrl [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [OCC_W-1:0]  r_occ;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_occ <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_ctrl[k] <= '0;
        r_data[k] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      r_occ <= '0;
      for (int k = 0; k < DEPTH; k++) r_ctrl[k] <= '0;
    end else if (!stall) begin
      r_valid[0] <= valid_in;
      r_ctrl[0] <= valid_in ? ctrl_in : '0;
      r_data[0] <= data_in;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_ctrl[k] <= r_ctrl[k-1];
        r_data[k] <= r_data[k-1];
      end
      r_occ <= r_occ - OCC_W'(r_valid[DEPTH-1]) + OCC_W'(valid_in);
    end
  end
  assign valid_out = r_valid[DEPTH-1];
  assign ctrl_out = r_ctrl[DEPTH-1];
  assign data_out = r_data[DEPTH-1];
  assign occupancy = r_occ;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (stall && !flush && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (!r_valid[DEPTH-1] && r_bubble_cnt != 32'hFFFF_FFFF) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end
  assign stall_cycles = r_stall_cnt;
  assign bubble_cycles = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: vector table plus randomized scoreboard run for a DEPTH=3 pipe_stage_reg
module tb_pipe_stage_reg;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int DP = 3;
  logic clk = 0;
  logic reset, stall, flush, valid_in;
  logic [CW-1:0] ctrl_in, ctrl_out;
  logic [DW-1:0] data_in, data_out;
  logic valid_out;
  logic [1:0] occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cycles, bubble_cycles;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
    .valid_out(valid_out), .ctrl_out(ctrl_out), .data_out(data_out),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
  );
  typedef struct {
    logic rst, stl, fl, v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic cd;
    logic [1:0] eo;
  } vec_t;
  vec_t tv[18];
  logic [CW+DW-1:0] q[$];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic vec_t mk(input logic rst, stl, fl, v, input logic [CW-1:0] c,
                              input logic [DW-1:0] d, input logic ev,
                              input logic [CW-1:0] ec, input logic [DW-1:0] ed,
                              input logic cd, input logic [1:0] eo);
    vec_t r;
    r.rst = rst; r.stl = stl; r.fl = fl; r.v = v; r.c = c; r.d = d;
    r.ev = ev; r.ec = ec; r.ed = ed; r.cd = cd; r.eo = eo;
    return r;
  endfunction
  task automatic drive(input logic rst, stl, fl, v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    reset = rst; stall = stl; flush = fl; valid_in = v; ctrl_in = c; data_in = d;
  endtask
  initial begin
    drive(1, 0, 0, 0, 0, 0);
    tv[0]  = mk(1, 1, 0, 1, 8'hFF, 16'h77, 0, 8'h00, 16'h0, 1, 0);
    tv[1]  = mk(0, 0, 0, 1, 8'h11, 16'h1,  0, 8'h00, 16'h0, 1, 1);
    tv[2]  = mk(0, 0, 0, 1, 8'h12, 16'h2,  0, 8'h00, 16'h0, 1, 2);
    tv[3]  = mk(0, 0, 0, 1, 8'h13, 16'h3,  1, 8'h11, 16'h1, 1, 3);
    tv[4]  = mk(0, 0, 0, 1, 8'h14, 16'h4,  1, 8'h12, 16'h2, 1, 3);
    tv[5]  = mk(0, 1, 0, 1, 8'h15, 16'h5,  1, 8'h12, 16'h2, 1, 3);
    tv[6]  = mk(0, 1, 0, 1, 8'h15, 16'h5,  1, 8'h12, 16'h2, 1, 3);
    tv[7]  = mk(0, 0, 0, 0, 8'hA5, 16'h6,  1, 8'h13, 16'h3, 1, 2);
    tv[8]  = mk(0, 0, 0, 0, 8'h00, 16'h7,  1, 8'h14, 16'h4, 1, 1);
    tv[9]  = mk(0, 0, 0, 1, 8'h20, 16'h8,  0, 8'h00, 16'h6, 1, 1);
    tv[10] = mk(0, 0, 0, 1, 8'h3C, 16'h9,  0, 8'h00, 16'h7, 1, 2);
    tv[11] = mk(0, 0, 0, 1, 8'h3C, 16'hA,  1, 8'h20, 16'h8, 1, 3);
    tv[12] = mk(0, 1, 1, 1, 8'h3C, 16'hB,  0, 8'h00, 16'h0, 0, 0);
    tv[13] = mk(0, 0, 0, 1, 8'h3C, 16'hC,  0, 8'h00, 16'h0, 0, 1);
    tv[14] = mk(0, 0, 0, 0, 8'h00, 16'h0,  0, 8'h00, 16'h0, 0, 1);
    tv[15] = mk(0, 0, 0, 0, 8'h00, 16'h0,  1, 8'h3C, 16'hC, 1, 1);
    tv[16] = mk(0, 0, 1, 1, 8'h55, 16'hD,  0, 8'h00, 16'h0, 0, 0);
    tv[17] = mk(1, 1, 1, 1, 8'hFF, 16'hE,  0, 8'h00, 16'h0, 1, 0);
    for (int i = 0; i < 18; i++) begin
      drive(tv[i].rst, tv[i].stl, tv[i].fl, tv[i].v, tv[i].c, tv[i].d);
      @(posedge clk); #1;
      chk($sformatf("vec%0d valid_out", i), 64'(valid_out), 64'(tv[i].ev));
      chk($sformatf("vec%0d ctrl_out", i), 64'(ctrl_out), 64'(tv[i].ec));
      if (tv[i].cd) chk($sformatf("vec%0d data_out", i), 64'(data_out), 64'(tv[i].ed));
      chk($sformatf("vec%0d occupancy", i), 64'(occupancy), 64'(tv[i].eo));
    end
    for (int i = 0; i < 400; i++) begin
      logic s, f, v, adv;
      logic [CW+DW-1:0] e;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 9) < 7);
      adv = !s && !f;
      drive(0, s, f, v, CW'($urandom), DW'($urandom));
      if (f) q.delete();
      else if (adv && v) q.push_back({ctrl_in, data_in});
      @(posedge clk); #1;
      if (adv && valid_out) begin
        if (q.size() == 0) chk("sb underflow", 64'(q.size()), 64'd1);
        else begin
          e = q.pop_front();
          chk("sb output", 64'({ctrl_out, data_out}), 64'(e));
        end
      end
      if (!valid_out) chk("sb bubble ctrl", 64'(ctrl_out), 64'd0);
      chk("sb occupancy", 64'(occupancy), 64'(q.size()) + 64'(valid_out));
    end
`ifdef PIPE_STAGE_PERF_EN
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("perf stall reset", 64'(stall_cycles), 64'd0);
    chk("perf bubble reset", 64'(bubble_cycles), 64'd0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 1, 8'h1, 16'h1);
      @(posedge clk); #1;
    end
    chk("perf stall count", 64'(stall_cycles), 64'd5);
    chk("perf bubble count", 64'(bubble_cycles), 64'd5);
    drive(1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("perf stall cleared", 64'(stall_cycles), 64'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
